cipher: RTL



---
 rtl/cipher.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/cipher.sv
// Iterative AES encryption core: one round per clock, round keys fetched by
// index from an external store with one-cycle read latency.
// Optional build macro CIPHER_BUSY_EN: adds a busy output and ignores en
// while a block is in flight (otherwise en restarts the sequence).
module cipher #(
    parameter int unsigned BLK_W    = 128,
    parameter int unsigned RK_IDX_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic [BLK_W-1:0]    plaintext,
    input  logic [RK_IDX_W-1:0] rounds_total,
    input  logic [BLK_W-1:0]    round_key,
    output logic [RK_IDX_W-1:0] round_key_no,
    output logic [BLK_W-1:0]    ciphertext,
`ifdef CIPHER_BUSY_EN
    output logic                busy,
`endif
    output logic                en_o
);

    localparam int unsigned NB   = BLK_W / 8;
    localparam int unsigned NCOL = BLK_W / 32;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // GF(2^8) multiply by 2, reduction polynomial 0x11B
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // byte-wise forward S-box substitution
    function automatic logic [BLK_W-1:0] sub_bytes(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int i = 0; i < int'(NB); i++) begin
            o[8*i +: 8] = SBOX[s[8*i +: 8]];
        end
        return o;
    endfunction

    // row r rotates left by r byte positions
    function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int c = 0; c < int'(NCOL); c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(r + 4*c) +: 8] = s[8*(r + 4*((c + r) % int'(NCOL))) +: 8];
            end
        end
        return o;
    endfunction

    // column mix with the {2,3,1,1} circulant matrix
    function automatic logic [BLK_W-1:0] mix_cols(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        logic [7:0]       a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < int'(NCOL); c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    logic [BLK_W-1:0]    pt_q;
    logic [RK_IDX_W-1:0] nr_q;
    logic [RK_IDX_W-1:0] round_no;
    logic                key_req;
    logic                round_en;
    logic                start_c;
    logic [BLK_W-1:0]    sr_c;
    logic [BLK_W-1:0]    next_state_c;

    // accept a new block; with busy tracking, only when idle or finishing
`ifdef CIPHER_BUSY_EN
    always_comb begin
        start_c = en && (!busy || en_o);
    end
`else
    always_comb begin
        start_c = en;
    end
`endif

    // next cipher state for the round currently being applied
    always_comb begin
        sr_c         = shift_rows(sub_bytes(ciphertext));
        next_state_c = sr_c ^ round_key;
        if (round_no == '0) begin
            next_state_c = pt_q ^ round_key;
        end else if (round_no != nr_q) begin
            next_state_c = mix_cols(sr_c) ^ round_key;
        end
    end

    // block capture and round-key index sequencing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pt_q         <= '0;
            nr_q         <= '0;
            round_key_no <= '0;
            key_req      <= 1'b0;
        end else if (start_c) begin
            pt_q         <= plaintext;
            nr_q         <= rounds_total;
            round_key_no <= '0;
            key_req      <= 1'b1;
        end else if (key_req) begin
            if (round_key_no < nr_q) begin
                round_key_no <= round_key_no + RK_IDX_W'(1);
            end else begin
                key_req <= 1'b0;
            end
        end
    end

    // round enable trails key requests by the store read latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            round_en <= 1'b0;
        end else begin
            round_en <= start_c ? 1'b0 : key_req;
        end
    end

    // round counter, state update and done strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            round_no   <= '0;
            ciphertext <= '0;
            en_o       <= 1'b0;
        end else if (start_c) begin
            round_no <= '0;
            en_o     <= 1'b0;
        end else begin
            en_o <= 1'b0;
            if (round_en) begin
                ciphertext <= next_state_c;
                if (round_no == nr_q) begin
                    round_no <= '0;
                    en_o     <= 1'b1;
                end else begin
                    round_no <= round_no + RK_IDX_W'(1);
                end
            end
        end
    end

`ifdef CIPHER_BUSY_EN
    // busy from the cycle after start through the done-strobe cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
        end else if (start_c) begin
            busy <= 1'b1;
        end else if (en_o) begin
            busy <= 1'b0;
        end
    end
`endif

endmodule
